// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: shares one L2 port between the I-cache and the D-cache.
// Only one L2 transaction can be outstanding. When both caches request at the
// same time, the grant alternates using round-robin. An I-cache cancel that
// arrives while its transaction is in flight lets the transaction finish on L2,
// but the result is dropped and no I_ack is sent.
//
// Handshakes:
//   I_req / D_req are level requests. The requester holds its request until it
//   sees the matching single-cycle ack pulse (or until I_cancel, for the I side).
//   L2_req is held with its op, addr and data stable until the single-cycle
//   L2_ack pulse. L2_req drops on the following edge.
//   An ack and its rd_data are valid in the same cycle.
module l1_l2_arbiter #(
  parameter int LINE_W = 512,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_req,
  input  logic [ADDR_W-1:0] I_req_addr,
  input  logic              I_cancel,
  input  logic              D_req,
  input  logic              D_req_op,
  input  logic [ADDR_W-1:0] D_req_addr,
  input  logic [LINE_W-1:0] D_wr_data,
  output logic              L2_req,
  output logic              L2_req_op,
  output logic [ADDR_W-1:0] L2_req_addr,
  output logic [LINE_W-1:0] L2_wr_data,
  input  logic              L2_ack,
  input  logic [LINE_W-1:0] L2_rd_data,
  output logic              I_ack,
  output logic              D_ack,
  output logic [LINE_W-1:0] I_rd_data,
  output logic [LINE_W-1:0] D_rd_data,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_I = 3'd1;
  localparam logic [2:0] BUSY_D = 3'd2;
  localparam logic [2:0] RESP_I = 3'd3;
  localparam logic [2:0] RESP_D = 3'd4;

  // Clears the offset bits within a 64-byte line.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(63);

  logic [2:0] state;
  logic       last_grant;  // 0 = I was granted last, 1 = D was granted last
  logic       drop;        // the in-flight I result must be discarded
  logic       i_ok;
  logic       grant_i;
  logic       grant_d;

  // Arbitration in IDLE. While I_cancel is high, an I request is not eligible.
  // When both sides request, the side that was not granted last wins.
  always_comb begin
    i_ok    = I_req & ~I_cancel;
    grant_i = i_ok & (~D_req | last_grant);
    grant_d = D_req & (~i_ok | ~last_grant);
  end

  assign dbg_state = state;

  // Main FSM together with all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      drop        <= 1'b0;
      L2_req      <= 1'b0;
      L2_req_op   <= 1'b0;
      L2_req_addr <= '0;
      L2_wr_data  <= '0;
      I_ack       <= 1'b0;
      D_ack       <= 1'b0;
      I_rd_data   <= '0;
      D_rd_data   <= '0;
    end else begin
      I_ack <= 1'b0;
      D_ack <= 1'b0;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (grant_i) begin
            state       <= BUSY_I;
            L2_req      <= 1'b1;
            L2_req_op   <= 1'b0;
            L2_req_addr <= I_req_addr & LINE_MASK;
            last_grant  <= 1'b0;
          end else if (grant_d) begin
            state       <= BUSY_D;
            L2_req      <= 1'b1;
            L2_req_op   <= D_req_op;
            L2_req_addr <= D_req_addr & LINE_MASK;
            L2_wr_data  <= D_wr_data;
            last_grant  <= 1'b1;
          end
        end
        BUSY_I: begin
          if (I_cancel) drop <= 1'b1;
          if (L2_ack) begin
            L2_req    <= 1'b0;
            I_rd_data <= L2_rd_data;
            if (drop || I_cancel) begin
              state <= IDLE;
              drop  <= 1'b0;
            end else begin
              state <= RESP_I;
              I_ack <= 1'b1;
            end
          end
        end
        BUSY_D: begin
          if (L2_ack) begin
            L2_req <= 1'b0;
            if (!L2_req_op) D_rd_data <= L2_rd_data;
            state  <= RESP_D;
            D_ack  <= 1'b1;
          end
        end
        RESP_I, RESP_D: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          L2_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter: directed scenarios for l1_l2_arbiter. The bench plays the
// L2 side itself. An expected-data scoreboard is filled when L2_ack is driven
// and is drained when the cache-side ack appears.
module tb_l1_l2_arbiter;

  localparam int LINE_W = 512;
  localparam int ADDR_W = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BUSY_I = 3'd1;
  localparam logic [2:0] ST_BUSY_D = 3'd2;
  localparam logic [2:0] ST_RESP_I = 3'd3;
  localparam logic [2:0] ST_RESP_D = 3'd4;

  logic              clk;
  logic              rst_n;
  logic              I_req;
  logic [ADDR_W-1:0] I_req_addr;
  logic              I_cancel;
  logic              D_req;
  logic              D_req_op;
  logic [ADDR_W-1:0] D_req_addr;
  logic [LINE_W-1:0] D_wr_data;
  logic              L2_req;
  logic              L2_req_op;
  logic [ADDR_W-1:0] L2_req_addr;
  logic [LINE_W-1:0] L2_wr_data;
  logic              L2_ack;
  logic [LINE_W-1:0] L2_rd_data;
  logic              I_ack;
  logic              D_ack;
  logic [LINE_W-1:0] I_rd_data;
  logic [LINE_W-1:0] D_rd_data;
  logic [2:0]        dbg_state;

  logic [LINE_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [LINE_W-1:0] last_d_rd;
  int                total;
  int                bad;

  l1_l2_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .I_req      (I_req),
    .I_req_addr (I_req_addr),
    .I_cancel   (I_cancel),
    .D_req      (D_req),
    .D_req_op   (D_req_op),
    .D_req_addr (D_req_addr),
    .D_wr_data  (D_wr_data),
    .L2_req     (L2_req),
    .L2_req_op  (L2_req_op),
    .L2_req_addr(L2_req_addr),
    .L2_wr_data (L2_wr_data),
    .L2_ack     (L2_ack),
    .L2_rd_data (L2_rd_data),
    .I_ack      (I_ack),
    .D_ack      (D_ack),
    .I_rd_data  (I_rd_data),
    .D_rd_data  (D_rd_data),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Called in the grant cycle. The task checks the L2 request, holds L2_ack off
  // for delay cycles, then completes the transaction and checks the ack pulse.
  task automatic serve(input int delay, input logic [LINE_W-1:0] rdata, input bit is_d,
                       input bit is_wr, input logic [LINE_W-1:0] wdata, input bit keep);
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] e;
    a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : '0;
    check("grant_req", LINE_W'(L2_req), LINE_W'(1));
    check("grant_state", LINE_W'(dbg_state), LINE_W'(is_d ? ST_BUSY_D : ST_BUSY_I));
    check("grant_addr", LINE_W'(L2_req_addr), LINE_W'(a));
    check("grant_op", LINE_W'(L2_req_op), LINE_W'(is_wr));
    if (is_wr) check("grant_wdata", L2_wr_data, wdata);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("hold_req", LINE_W'(L2_req), LINE_W'(1));
      check("hold_addr", LINE_W'(L2_req_addr), LINE_W'(a));
      if (is_wr) check("hold_wdata", L2_wr_data, wdata);
    end
    L2_ack     = 1'b1;
    L2_rd_data = rdata;
    if (is_d) begin
      if (!is_wr) last_d_rd = rdata;
      exp_q.push_back(last_d_rd);
    end else begin
      exp_q.push_back(rdata);
    end
    tick();
    L2_ack     = 1'b0;
    L2_rd_data = '0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("resp_req_drop", LINE_W'(L2_req), LINE_W'(0));
    check("resp_state", LINE_W'(dbg_state), LINE_W'(is_d ? ST_RESP_D : ST_RESP_I));
    if (is_d) begin
      check("d_ack", LINE_W'(D_ack), LINE_W'(1));
      check("d_ack_other", LINE_W'(I_ack), LINE_W'(0));
      check("d_rd_data", D_rd_data, e);
      if (!keep) D_req = 1'b0;
    end else begin
      check("i_ack", LINE_W'(I_ack), LINE_W'(1));
      check("i_ack_other", LINE_W'(D_ack), LINE_W'(0));
      check("i_rd_data", I_rd_data, e);
      if (!keep) I_req = 1'b0;
    end
    tick();
    check("ack_end_i", LINE_W'(I_ack), LINE_W'(0));
    check("ack_end_d", LINE_W'(D_ack), LINE_W'(0));
    check("back_idle", LINE_W'(dbg_state), LINE_W'(ST_IDLE));
  endtask

  initial begin
    logic [LINE_W-1:0] pat;
    logic [LINE_W-1:0] wline;
    total      = 0;
    bad        = 0;
    last_d_rd  = '0;
    rst_n      = 1'b0;
    I_req      = 1'b1;
    I_req_addr = 32'h1234_5678;
    I_cancel   = 1'b0;
    D_req      = 1'b0;
    D_req_op   = 1'b0;
    D_req_addr = '0;
    D_wr_data  = '0;
    L2_ack     = 1'b0;
    L2_rd_data = '0;

    // Reset values
    repeat (3) tick();
    check("rst_l2_req", LINE_W'(L2_req), LINE_W'(0));
    check("rst_l2_op", LINE_W'(L2_req_op), LINE_W'(0));
    check("rst_l2_addr", LINE_W'(L2_req_addr), LINE_W'(0));
    check("rst_l2_wdata", L2_wr_data, '0);
    check("rst_i_ack", LINE_W'(I_ack), LINE_W'(0));
    check("rst_d_ack", LINE_W'(D_ack), LINE_W'(0));
    check("rst_i_rd", I_rd_data, '0);
    check("rst_d_rd", D_rd_data, '0);
    check("rst_state", LINE_W'(dbg_state), LINE_W'(ST_IDLE));
    I_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // Simultaneous requests, held: I wins the first tie, then D, then I
    I_req      = 1'b1;
    I_req_addr = 32'h0000_2040;
    D_req      = 1'b1;
    D_req_op   = 1'b0;
    D_req_addr = 32'h0000_3000;
    exp_addr_q.push_back(32'h0000_2040);
    exp_addr_q.push_back(32'h0000_3000);
    exp_addr_q.push_back(32'h0000_2040);
    for (int r = 0; r < 3; r++) begin
      tick();
      serve($urandom_range(0, 3), rand_line(), r == 1, 1'b0, '0, r < 2);
    end
    D_req = 1'b0;
    tick();

    // Single I read at an unaligned address, with the ack two cycles later
    for (int i = 0; i < LINE_W / 8; i++) pat[i*8 +: 8] = 8'hA5;
    I_req      = 1'b1;
    I_req_addr = 32'h1C00_0047;
    exp_addr_q.push_back(32'h1C00_0040);
    tick();
    serve(2, pat, 1'b0, 1'b0, '0, 1'b0);

    // D write-back: the write line goes out and D_rd_data holds its value
    for (int i = 0; i < LINE_W / 8; i++) wline[i*8 +: 8] = 8'(i);
    D_req      = 1'b1;
    D_req_op   = 1'b1;
    D_req_addr = 32'h0000_1000;
    D_wr_data  = wline;
    exp_addr_q.push_back(32'h0000_1000);
    tick();
    serve(3, rand_line(), 1'b1, 1'b1, wline, 1'b0);
    D_req_op  = 1'b0;
    D_wr_data = '0;

    // I_cancel while BUSY_I with D pending: no I_ack, then D is granted
    I_req      = 1'b1;
    I_req_addr = 32'h0000_5000;
    tick();
    check("cancel_grant", LINE_W'(dbg_state), LINE_W'(ST_BUSY_I));
    D_req      = 1'b1;
    D_req_addr = 32'h0000_6000;
    I_cancel   = 1'b1;
    I_req      = 1'b0;
    tick();
    I_cancel = 1'b0;
    tick();
    L2_ack     = 1'b1;
    L2_rd_data = rand_line();
    tick();
    L2_ack = 1'b0;
    check("cancel_no_iack", LINE_W'(I_ack), LINE_W'(0));
    check("cancel_no_dack", LINE_W'(D_ack), LINE_W'(0));
    check("cancel_idle", LINE_W'(dbg_state), LINE_W'(ST_IDLE));
    check("cancel_req_drop", LINE_W'(L2_req), LINE_W'(0));
    tick();
    exp_addr_q.push_back(32'h0000_6000);
    serve(1, rand_line(), 1'b1, 1'b0, '0, 1'b0);

    // A stray L2_ack in IDLE is ignored
    L2_ack = 1'b1;
    tick();
    L2_ack = 1'b0;
    check("stray_state", LINE_W'(dbg_state), LINE_W'(ST_IDLE));
    check("stray_iack", LINE_W'(I_ack), LINE_W'(0));
    check("stray_dack", LINE_W'(D_ack), LINE_W'(0));
    check("stray_req", LINE_W'(L2_req), LINE_W'(0));
    tick();
    check("stray_state2", LINE_W'(dbg_state), LINE_W'(ST_IDLE));

    // Reset asserted during BUSY_D, released with D_req still high
    D_req      = 1'b1;
    D_req_addr = 32'h0000_7000;
    tick();
    check("rst_mid_busy", LINE_W'(dbg_state), LINE_W'(ST_BUSY_D));
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", LINE_W'(L2_req), LINE_W'(0));
    check("rst_mid_state", LINE_W'(dbg_state), LINE_W'(ST_IDLE));
    last_d_rd = '0;
    tick();
    tick();
    check("rst_mid_req2", LINE_W'(L2_req), LINE_W'(0));
    check("rst_mid_dack", LINE_W'(D_ack), LINE_W'(0));
    rst_n = 1'b1;
    tick();
    exp_addr_q.push_back(32'h0000_7000);
    serve(1, rand_line(), 1'b1, 1'b0, '0, 1'b0);
    tick();
    check("final_idle", LINE_W'(dbg_state), LINE_W'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_l2_arbiter.md
L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

Interface
REQ-001 Parameter LINE_W, default 512, cache line width in bits.
REQ-002 Parameter ADDR_W, default 32, request address width in bits.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 I_req  input  1  I-cache line-read request; level, held until I_ack or I_cancel.
REQ-006 I_req_addr  input  ADDR_W  I-cache line address, bits [5:0] ignored.
REQ-007 I_cancel  input  1  I-cache flush/exception; the outstanding I result is dropped.
REQ-008 D_req  input  1  D-cache request; level, held until D_ack.
REQ-009 D_req_op  input  1  D-cache operation: 0 = read, 1 = write-back.
REQ-010 D_req_addr  input  ADDR_W  D-cache line address.
REQ-011 D_wr_data  input  LINE_W  D-cache write-back line.
REQ-012 L2_req  output  1  request to L2, registered.
REQ-013 L2_req_op  output  1  0 = read, 1 = write, registered.
REQ-014 L2_req_addr  output  ADDR_W  registered address; bits [5:0] are forced to 0.
REQ-015 L2_wr_data  output  LINE_W  registered write line.
REQ-016 L2_ack  input  1  single-cycle completion from L2.
REQ-017 L2_rd_data  input  LINE_W  read line, valid with L2_ack.
REQ-018 I_ack / D_ack  output  1 each  single-cycle completion pulses, registered.
REQ-019 I_rd_data / D_rd_data  output  LINE_W each  registered read line, valid with the matching ack.

Function
REQ-020 The block SHALL implement five states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
REQ-021 IDLE: if I_req and not D_req, the block SHALL go to BUSY_I; if D_req and not I_req, it SHALL go to BUSY_D; if both, round-robin SHALL grant the requester not recorded in last_grant.
REQ-022 I_req SHALL be ignored in IDLE while I_cancel is high.
REQ-023 On the grant edge the block SHALL:
  - latch addr, op and wr_data (op = 0 for an I grant);
  - set L2_req = 1;
  - update last_grant (0 = I, 1 = D).
REQ-024 BUSY_x: L2_req, op, addr and data SHALL stay stable until L2_ack, then L2_req SHALL drop on the next edge.
REQ-025 BUSY_x with L2_ack:
  - L2_rd_data SHALL be latched into x_rd_data;
  - the state SHALL go to RESP_x;
  - for BUSY_I with the drop flag set, the state SHALL instead go to IDLE with no I_ack.
REQ-026 RESP_x: x_ack SHALL be 1 for exactly this one cycle, then the state SHALL return to IDLE.
REQ-027 No arbitration SHALL occur in RESP_x; the requester deasserts req in that cycle.
REQ-028 Drop flag: I_cancel high in BUSY_I (including the L2_ack cycle) SHALL set the flag.
REQ-029 The drop flag SHALL clear on entering IDLE.
REQ-030 An L2 transaction is never aborted; it always completes before the next grant.
REQ-031 D_rd_data SHALL update only on D reads; on writes it holds its previous value while D_ack still pulses.
REQ-032 L2_ack in IDLE or RESP_x SHALL be ignored, with no state change and no ack.
REQ-033 Latency: req sampled in IDLE at cycle N gives L2_req = 1 at N+1; L2_ack at cycle M gives x_ack at M+1 and IDLE at M+2.
REQ-034 Minimum spacing between consecutive grants SHALL be 3 cycles (grant, ack, resp).
REQ-035 At most one transaction SHALL be outstanding at any time.

Reset
REQ-036 During reset all outputs SHALL be 0:
  - L2_req, L2_req_op, L2_req_addr, L2_wr_data;
  - I_ack, D_ack, I_rd_data, D_rd_data.
REQ-037 During reset: state = IDLE, last_grant = 1 (so I wins the first tie), drop flag = 0.
REQ-038 Reset asserted mid-transaction SHALL return the block to IDLE immediately with L2_req = 0; there is no pending ack after release.

Verification
REQ-039 I_req = 1, addr 0x1C00_0047; L2_ack two cycles later with data 0xA5 pattern -> L2_req_addr = 0x1C00_0040, op 0; I_ack is a one-cycle pulse with I_rd_data = pattern; D_ack stays 0.
REQ-040 I_req and D_req rise in the same cycle, held, two rounds -> grant order I, D, I.
REQ-041 D write-back, addr 0x0000_1000, data incrementing bytes -> L2_req_op = 1, L2_wr_data matches and is stable until L2_ack; D_ack pulses; D_rd_data unchanged.
REQ-042 I_cancel pulsed in BUSY_I before L2_ack, D_req pending -> no I_ack; IDLE follows the ack cycle; D is granted next.
REQ-043 Stray L2_ack in IDLE -> no ack pulses; state stays IDLE.
REQ-044 rst_n low in BUSY_D, released with D_req still high -> L2_req = 0 during reset; a new D grant with L2_req = 1 one cycle after the first IDLE sample.
